// File: rtl/formula_chain_pkg.sv
// Shared types and parameter limits for the nested square-root chain.
// Optional build macro used by this slice: FORMULA_CHAIN_SAT_EN.
package formula_chain_pkg;

   localparam int N_TERMS_MIN = 1;
   localparam int N_TERMS_MAX = 16;
   localparam int W_MIN       = 8;
   localparam int W_MAX       = 64;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT,
      DONE
   } fc_state_t;

endpackage

// File: rtl/formula_chain_add.sv
// W-bit term adder: a + zero-extended isqrt result.
// Wraps by default; saturates to all-ones on carry-out when FORMULA_CHAIN_SAT_EN is defined.
module formula_chain_add #(
   parameter int W = 32
) (
   input  logic [W-1:0]   a,
   input  logic [W/2-1:0] b,
   output logic [W-1:0]   sum
);

`ifdef FORMULA_CHAIN_SAT_EN
   logic [W:0] full;

   assign full = {1'b0, a} + {{(W/2+1){1'b0}}, b};
   assign sum  = full[W] ? '1 : full[W-1:0];
`else
   assign sum = a + {{(W/2){1'b0}}, b};
`endif

endmodule

// File: rtl/formula_chain_fsm.sv
// Sequences res = isqrt(a0 + isqrt(a1 + ... isqrt(a[N-1]))) through one external isqrt unit.
// Build macro FORMULA_CHAIN_SAT_EN selects saturating instead of wrapping term sums.
//
// Handshakes: a vector is taken in the cycle arg_vld and arg_rdy are both high;
// isqrt_x_vld is a one-cycle request strobe and isqrt_y_vld is honoured only while
// waiting for it; res_vld is a one-cycle strobe and res holds until the next result.
module formula_chain_fsm
   import formula_chain_pkg::*;
#(
   parameter int N_TERMS = 3,
   parameter int W       = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 arg_vld,
   output logic                 arg_rdy,
   input  logic [N_TERMS*W-1:0] args,
   output logic                 res_vld,
   output logic [W-1:0]         res,
   output logic                 isqrt_x_vld,
   output logic [W-1:0]         isqrt_x,
   input  logic                 isqrt_y_vld,
   input  logic [W/2-1:0]       isqrt_y,
   output fc_state_t            dbg_state
);

   localparam int IW = $clog2(N_TERMS + 1);

   if (N_TERMS < N_TERMS_MIN || N_TERMS > N_TERMS_MAX ||
       W < W_MIN || W > W_MAX || (W % 2) != 0) begin : g_bad_params
      $error("formula_chain_fsm: illegal N_TERMS or W");
   end

   fc_state_t            state;
   logic [IW-1:0]        idx;
   logic [IW-1:0]        idx_m1;
   logic [W-1:0]         acc;
   logic [N_TERMS*W-1:0] terms_q;
   logic [W-1:0]         term_sel;
   logic [W-1:0]         sum;

   // Term a[idx-1] feeds the adder; idx==0 never uses the sum.
   assign idx_m1 = idx - IW'(1);

   always_comb begin
      term_sel = '0;
      for (int i = 0; i < N_TERMS; i++) begin
         if (idx_m1 == IW'(i)) term_sel = terms_q[i*W +: W];
      end
   end

   formula_chain_add #(.W(W)) u_add (
      .a   (term_sel),
      .b   (isqrt_y),
      .sum (sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         acc         <= '0;
         res         <= '0;
         terms_q     <= '0;
         arg_rdy     <= 1'b1;
         res_vld     <= 1'b0;
         isqrt_x_vld <= 1'b0;
      end else begin
         res_vld     <= 1'b0;
         isqrt_x_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (arg_vld) begin
                  terms_q     <= args;
                  acc         <= args[(N_TERMS-1)*W +: W];
                  idx         <= IW'(N_TERMS - 1);
                  arg_rdy     <= 1'b0;
                  isqrt_x_vld <= 1'b1;
                  state       <= SEND;
               end
            end
            SEND: state <= WAIT;
            WAIT: begin
               if (isqrt_y_vld) begin
                  if (idx != '0) begin
                     acc         <= sum;
                     idx         <= idx - IW'(1);
                     isqrt_x_vld <= 1'b1;
                     state       <= SEND;
                  end else begin
                     res     <= {{(W/2){1'b0}}, isqrt_y};
                     res_vld <= 1'b1;
                     state   <= DONE;
                  end
               end
            end
            DONE: begin
               arg_rdy <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign isqrt_x   = acc;
   assign dbg_state = state;

endmodule
